// File: rtl/vme_pkg.sv
// rtl/vme_pkg.sv - shared constants, state encoding and priority helper for the VME slot-1 arbiter
package vme_pkg;

  localparam logic ACTIVE    = 1'b0;
  localparam logic INACTIVE  = 1'b1;
  localparam int   BR_LEVELS = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    OWNED   = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  // Highest active (low) request level wins; level 0 when nothing is requested.
  function automatic logic [1:0] fixed_winner(input logic [BR_LEVELS-1:0] br_n);
    logic [1:0] lvl;
    lvl = 2'd0;
    for (int i = 0; i < BR_LEVELS; i++) begin
      if (br_n[i] == ACTIVE) lvl = 2'(i);
    end
    return lvl;
  endfunction

endpackage

// File: rtl/vme_bus_timer.sv
// rtl/vme_bus_timer.sv - bus-timeout watchdog terminating stalled data transfers with BERR
module vme_bus_timer
  import vme_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 800,
  parameter int TIMEOUT_WIDTH  = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable_i,
  input  logic       as_i,
  input  logic [1:0] ds_i,
  input  logic       dtack_i,
  input  logic       berr_i,
  output logic       berr_o
);

  logic [TIMEOUT_WIDTH-1:0] count_q, count_d;
  logic                     berr_q, berr_d;
  logic                     ds_idle;
  logic                     cycle_live;

  // Count stalled-cycle clocks; fire once at the threshold and hold until DS drops.
  always_comb begin
    ds_idle    = (ds_i == {2{INACTIVE}});
    cycle_live = (as_i == ACTIVE) && !ds_idle && (dtack_i == INACTIVE) && (berr_i == INACTIVE);
    count_d    = count_q;
    berr_d     = berr_q;

    if (!cycle_live) begin
      count_d = '0;
    end else if (count_q != '1) begin
      count_d = count_q + 1'b1;
    end

    if (berr_q == ACTIVE) begin
      if (ds_idle) begin
        berr_d  = INACTIVE;
        count_d = '0;
      end
    end else if (count_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES)) begin
      berr_d = ACTIVE;
    end

    if (!enable_i) begin
      count_d = '0;
      berr_d  = INACTIVE;
    end
  end

  // Counter and BERR registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      berr_q  <= INACTIVE;
    end else begin
      count_q <= count_d;
      berr_q  <= berr_d;
    end
  end

  assign berr_o = berr_q;

endmodule

// File: rtl/vme_system_arbiter.sv
// rtl/vme_system_arbiter.sv - VME slot-1 bus arbiter with BCLR preemption; VME_ARB_ROUND_ROBIN_EN selects round-robin
module vme_system_arbiter
  import vme_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 800,
  parameter int TIMEOUT_WIDTH  = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       slot1_en,
  input  logic [3:0] vme_br,
  input  logic       vme_as,
  input  logic [1:0] vme_ds,
  input  logic       vme_dtack,
  input  logic       vme_berr_in,
  output logic [3:0] vme_bg_out,
  output logic       vme_bclr,
  output logic       vme_berr_out,
  output logic [1:0] grant_level,
  output logic       arb_busy
);

  localparam int SYNC_W = BR_LEVELS + 5;

  logic [SYNC_W-1:0]    meta_q, sync_q;
  logic [BR_LEVELS-1:0] br_s;
  logic                 as_s, dtack_s, berr_s;
  logic [1:0]           ds_s;
  logic                 enabled;

  arb_state_t           state_q, state_d;
  logic [1:0]           level_q, level_d;
  logic [BR_LEVELS-1:0] bg_q, bg_d;
  logic                 bclr_q, bclr_d;
  logic                 busy_q, busy_d;
  logic [1:0]           winner;
  logic                 any_req, owner_req;

  // First synchronizer stage samples the backplane on the falling edge.
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) meta_q <= '1;
    else        meta_q <= {vme_br, vme_as, vme_ds, vme_dtack, vme_berr_in};
  end

  // Second synchronizer stage re-times onto the rising edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sync_q <= '1;
    else        sync_q <= meta_q;
  end

  assign {br_s, as_s, ds_s, dtack_s, berr_s} = sync_q;
  assign enabled   = (slot1_en == ACTIVE);
  assign any_req   = (br_s != {BR_LEVELS{INACTIVE}});
  assign owner_req = (br_s[level_q] == ACTIVE);

`ifdef VME_ARB_ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] cand;
  logic       found;

  // Round-robin search starting one level below the last grant, wrapping 0 -> 3.
  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    cand   = ptr_q;
    for (int k = 1; k <= BR_LEVELS; k++) begin
      cand = ptr_q - 2'(k);
      if (!found && br_s[cand] == ACTIVE) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end
`else
  logic higher_req;

  // Fixed priority: level 3 highest; any request above the owner triggers preemption.
  always_comb begin
    winner     = fixed_winner(br_s);
    higher_req = |(~br_s & (4'b1110 << level_q));
  end
`endif

  // Arbiter next state; BG/BCLR/busy are decoded from the current state and registered.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    bg_d    = {BR_LEVELS{INACTIVE}};
    bclr_d  = INACTIVE;
    busy_d  = INACTIVE;
`ifdef VME_ARB_ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif

    case (state_q)
      IDLE: begin
        if (any_req && as_s == INACTIVE) begin
          level_d = winner;
          state_d = GRANT;
`ifdef VME_ARB_ROUND_ROBIN_EN
          ptr_d   = winner;
`endif
        end
      end
      GRANT: begin
        bg_d[level_q] = ACTIVE;
        busy_d        = ACTIVE;
        if (as_s == ACTIVE)  state_d = OWNED;
        else if (!owner_req) state_d = RELEASE;
      end
      OWNED: begin
        bg_d[level_q] = ACTIVE;
        busy_d        = ACTIVE;
`ifndef VME_ARB_ROUND_ROBIN_EN
        if (higher_req || bclr_q == ACTIVE) bclr_d = ACTIVE;
`endif
        if (!owner_req && as_s == INACTIVE) state_d = RELEASE;
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (!enabled) begin
      state_d = IDLE;
      bg_d    = {BR_LEVELS{INACTIVE}};
      bclr_d  = INACTIVE;
      busy_d  = INACTIVE;
    end
  end

  // Arbiter state and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      level_q <= 2'd0;
      bg_q    <= {BR_LEVELS{INACTIVE}};
      bclr_q  <= INACTIVE;
      busy_q  <= INACTIVE;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      bg_q    <= bg_d;
      bclr_q  <= bclr_d;
      busy_q  <= busy_d;
    end
  end

`ifdef VME_ARB_ROUND_ROBIN_EN
  // Last-granted pointer; zero after reset so level 3 is searched first.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ptr_q <= 2'd0;
    else        ptr_q <= ptr_d;
  end
`endif

  vme_bus_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
  ) u_bus_timer (
    .clock    (clock),
    .reset    (reset),
    .enable_i (enabled),
    .as_i     (as_s),
    .ds_i     (ds_s),
    .dtack_i  (dtack_s),
    .berr_i   (berr_s),
    .berr_o   (vme_berr_out)
  );

  assign vme_bg_out  = bg_q;
  assign vme_bclr    = bclr_q;
  assign grant_level = level_q;
  assign arb_busy    = busy_q;

endmodule

// File: tb/tb_vme_system_arbiter.sv
// tb/tb_vme_system_arbiter.sv - self-checking bench for vme_system_arbiter
module tb_vme_system_arbiter;

  localparam int TOUT = 8;
  localparam int TW   = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       slot1_en = 1'b0;
  logic [3:0] vme_br = 4'hF;
  logic       vme_as = 1'b1;
  logic [1:0] vme_ds = 2'b11;
  logic       vme_dtack = 1'b1;
  logic       vme_berr_in = 1'b1;
  logic [3:0] vme_bg_out;
  logic       vme_bclr;
  logic       vme_berr_out;
  logic [1:0] grant_level;
  logic       arb_busy;

  int checks = 0;
  int errors = 0;
  int model_ptr = 0;

  vme_system_arbiter #(.TIMEOUT_CYCLES(TOUT), .TIMEOUT_WIDTH(TW)) dut (
    .clock        (clock),
    .reset        (reset),
    .slot1_en     (slot1_en),
    .vme_br       (vme_br),
    .vme_as       (vme_as),
    .vme_ds       (vme_ds),
    .vme_dtack    (vme_dtack),
    .vme_berr_in  (vme_berr_in),
    .vme_bg_out   (vme_bg_out),
    .vme_bclr     (vme_bclr),
    .vme_berr_out (vme_berr_out),
    .grant_level  (grant_level),
    .arb_busy     (arb_busy)
  );

  always #5 clock = ~clock;

  // Reference: which level should win given the set of active requests (active-high mask).
  function automatic int model_winner(input logic [3:0] req, input int ptr);
`ifdef VME_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= 4; k++) begin
      int l;
      l = (ptr - k + 8) % 4;
      if (req[l]) return l;
    end
    return -1;
`else
    for (int l = 3; l >= 0; l--) begin
      if (req[l]) return l;
    end
    return -1;
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_bg(input logic [3:0] want, input int limit, output int cycles);
    cycles = 0;
    while (vme_bg_out !== want && cycles < limit) begin
      tick(1);
      cycles++;
    end
  endtask

  task automatic wait_grant(input int limit, output int cycles);
    cycles = 0;
    while (vme_bg_out === 4'hF && cycles < limit) begin
      tick(1);
      cycles++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick(2);
    checks++;
    if ({vme_bg_out, vme_bclr, vme_berr_out, arb_busy, grant_level} !== {4'hF, 1'b1, 1'b1, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL reset_values: bg=%b bclr=%b berr=%b busy=%b lvl=%0d expected 1111 1 1 1 0",
               vme_bg_out, vme_bclr, vme_berr_out, arb_busy, grant_level);
    end
    reset = 1'b1;
    model_ptr = 0;
    tick(4);
    checks++;
    if (vme_bg_out !== 4'hF || arb_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_idle: bg=%b busy=%b expected 1111 1", vme_bg_out, arb_busy);
    end
  endtask

  task automatic test_single;
    int c;
    int lvl;
    logic [3:0] exp_bg;
    lvl = model_winner(4'b0010, model_ptr);
    exp_bg = 4'hF;
    exp_bg[lvl] = 1'b0;
    vme_br = 4'b1101;
    wait_grant(8, c);
    checks++;
    if (vme_bg_out !== exp_bg || c > 4) begin
      errors++;
      $display("FAIL single_grant: bg=%b after %0d clocks expected %b within 4", vme_bg_out, c, exp_bg);
    end
    checks++;
    if (grant_level !== 2'(lvl) || arb_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_status: lvl=%0d busy=%b expected %0d 0", grant_level, arb_busy, lvl);
    end
    model_ptr = lvl;
    vme_as = 1'b0;
    tick(3);
    checks++;
    if (vme_bg_out !== exp_bg || vme_bclr !== 1'b1) begin
      errors++;
      $display("FAIL single_owned: bg=%b bclr=%b expected %b 1", vme_bg_out, vme_bclr, exp_bg);
    end
    vme_br = 4'hF;
    vme_as = 1'b1;
    wait_bg(4'hF, 8, c);
    checks++;
    if (vme_bg_out !== 4'hF || c > 3) begin
      errors++;
      $display("FAIL single_release: bg=%b after %0d clocks expected 1111 within 3", vme_bg_out, c);
    end
    tick(2);
    checks++;
    if (arb_busy !== 1'b1 || vme_bg_out !== 4'hF) begin
      errors++;
      $display("FAIL single_idle: busy=%b bg=%b expected 1 1111", arb_busy, vme_bg_out);
    end
  endtask

  task automatic test_simultaneous;
    int c;
    int lvl;
    logic [3:0] mask;
    logic [3:0] exp_bg;
    mask = 4'b0101;
    lvl = model_winner(mask, model_ptr);
    exp_bg = 4'hF;
    exp_bg[lvl] = 1'b0;
    vme_br = ~mask;
    wait_grant(8, c);
    checks++;
    if (vme_bg_out !== exp_bg) begin
      errors++;
      $display("FAIL simul_first: bg=%b expected %b", vme_bg_out, exp_bg);
    end
    model_ptr = lvl;
    vme_as = 1'b0;
    tick(2);
    mask[lvl] = 1'b0;
    vme_br = ~mask;
    vme_as = 1'b1;
    wait_bg(4'hF, 8, c);
    lvl = model_winner(mask, model_ptr);
    exp_bg = 4'hF;
    exp_bg[lvl] = 1'b0;
    wait_grant(10, c);
    checks++;
    if (vme_bg_out !== exp_bg || c < 2) begin
      errors++;
      $display("FAIL simul_second: bg=%b gap=%0d expected %b with gap>=2", vme_bg_out, c, exp_bg);
    end
    model_ptr = lvl;
    vme_as = 1'b0;
    tick(2);
    vme_br = 4'hF;
    vme_as = 1'b1;
    wait_bg(4'hF, 8, c);
    tick(2);
  endtask

`ifndef VME_ARB_ROUND_ROBIN_EN
  task automatic test_preemption;
    int c;
    logic held;
    vme_br = 4'b1110;
    wait_grant(8, c);
    checks++;
    if (vme_bg_out !== 4'b1110) begin
      errors++;
      $display("FAIL preempt_owner: bg=%b expected 1110", vme_bg_out);
    end
    model_ptr = 0;
    vme_as = 1'b0;
    tick(2);
    vme_br = 4'b0110;
    c = 0;
    while (vme_bclr !== 1'b0 && c < 6) begin
      tick(1);
      c++;
    end
    checks++;
    if (vme_bclr !== 1'b0 || c > 3) begin
      errors++;
      $display("FAIL preempt_bclr: bclr=%b after %0d clocks expected 0 within 3", vme_bclr, c);
    end
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (vme_bg_out !== 4'b1110 || vme_bclr !== 1'b0) held = 1'b0;
    end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL preempt_hold: bg=%b bclr=%b expected 1110 0 throughout", vme_bg_out, vme_bclr);
    end
    vme_br = 4'b0111;
    vme_as = 1'b1;
    wait_bg(4'b0111, 10, c);
    checks++;
    if (vme_bg_out !== 4'b0111 || vme_bclr !== 1'b1) begin
      errors++;
      $display("FAIL preempt_handover: bg=%b bclr=%b expected 0111 1", vme_bg_out, vme_bclr);
    end
    vme_as = 1'b0;
    tick(2);
    vme_br = 4'hF;
    vme_as = 1'b1;
    wait_bg(4'hF, 8, c);
    tick(2);
  endtask
`else
  task automatic test_round_robin;
    int c;
    int lvl;
    int prev;
    logic [3:0] exp_bg;
    prev = -1;
    vme_br = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      lvl = model_winner(4'b1010, model_ptr);
      exp_bg = 4'hF;
      exp_bg[lvl] = 1'b0;
      wait_grant(10, c);
      checks++;
      if (vme_bg_out !== exp_bg || vme_bclr !== 1'b1 || lvl == prev) begin
        errors++;
        $display("FAIL rr_grant%0d: bg=%b bclr=%b expected %b 1", i, vme_bg_out, vme_bclr, exp_bg);
      end
      model_ptr = lvl;
      prev = lvl;
      vme_as = 1'b0;
      tick(3);
      checks++;
      if (vme_bclr !== 1'b1) begin
        errors++;
        $display("FAIL rr_bclr%0d: bclr=%b expected 1", i, vme_bclr);
      end
      vme_br[lvl] = 1'b1;
      vme_as = 1'b1;
      wait_bg(4'hF, 8, c);
      vme_br[lvl] = 1'b0;
    end
    vme_br = 4'hF;
    tick(3);
    wait_bg(4'hF, 8, c);
    if (vme_bg_out === 4'hF) begin
      // a late grant may have started for the last re-assert; drain it
      tick(1);
    end
    vme_as = 1'b0;
    tick(1);
    vme_as = 1'b1;
    tick(6);
  endtask
`endif

  task automatic test_random;
    for (int r = 0; r < 8; r++) begin
      logic [3:0] mask;
      logic [3:0] exp_bg;
      int c;
      int lvl;
      mask = 4'($urandom_range(1, 15));
      vme_br = ~mask;
      while (mask != 4'h0) begin
        lvl = model_winner(mask, model_ptr);
        exp_bg = 4'hF;
        exp_bg[lvl] = 1'b0;
        wait_grant(10, c);
        checks++;
        if (vme_bg_out !== exp_bg || grant_level !== 2'(lvl)) begin
          errors++;
          $display("FAIL rand_grant: mask=%b bg=%b lvl=%0d expected %b %0d", mask, vme_bg_out, grant_level, exp_bg, lvl);
        end
        model_ptr = lvl;
        vme_as = 1'b0;
        tick(int'($urandom_range(1, 4)));
        mask[lvl] = 1'b0;
        vme_br = ~mask;
        vme_as = 1'b1;
        wait_bg(4'hF, 6, c);
        checks++;
        if (vme_bg_out !== 4'hF || c > 3) begin
          errors++;
          $display("FAIL rand_release: bg=%b after %0d clocks expected 1111 within 3", vme_bg_out, c);
        end
      end
      tick(3);
    end
  endtask

  task automatic test_timeout;
    int c;
    logic seen;
    vme_as = 1'b0;
    vme_ds = 2'b10;
    c = 0;
    while (vme_berr_out !== 1'b0 && c < 20) begin
      tick(1);
      c++;
    end
    checks++;
    if (vme_berr_out !== 1'b0 || c != TOUT + 2) begin
      errors++;
      $display("FAIL timeout_fire: berr=%b after %0d clocks expected 0 at %0d", vme_berr_out, c, TOUT + 2);
    end
    checks++;
    if (vme_bg_out !== 4'hF || arb_busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_fsm: bg=%b busy=%b expected 1111 1", vme_bg_out, arb_busy);
    end
    vme_ds = 2'b11;
    c = 0;
    while (vme_berr_out !== 1'b1 && c < 5) begin
      tick(1);
      c++;
    end
    checks++;
    if (vme_berr_out !== 1'b1 || c > 2) begin
      errors++;
      $display("FAIL timeout_release: berr=%b after %0d clocks expected 1 within 2", vme_berr_out, c);
    end
    vme_as = 1'b1;
    tick(2);
    vme_as = 1'b0;
    vme_ds = 2'b10;
    tick(5);
    vme_dtack = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (vme_berr_out !== 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL timeout_dtack: berr went low, expected it to stay 1");
    end
    vme_as = 1'b1;
    vme_ds = 2'b11;
    vme_dtack = 1'b1;
    tick(3);
  endtask

  task automatic test_slot1_disabled;
    logic quiet;
    slot1_en = 1'b1;
    vme_br = 4'b1110;
    quiet = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (vme_bg_out !== 4'hF || arb_busy !== 1'b1) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL slot1_disabled: bg=%b busy=%b expected 1111 1 throughout", vme_bg_out, arb_busy);
    end
    vme_br = 4'hF;
    slot1_en = 1'b0;
    tick(3);
  endtask

  task automatic test_reset_mid;
    int c;
    vme_br = 4'b1011;
    wait_grant(8, c);
    checks++;
    if (vme_bg_out !== 4'b1011) begin
      errors++;
      $display("FAIL midreset_grant: bg=%b expected 1011", vme_bg_out);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (vme_bg_out !== 4'hF || arb_busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_async: bg=%b busy=%b expected 1111 1", vme_bg_out, arb_busy);
    end
    tick(2);
    reset = 1'b1;
    model_ptr = 0;
    wait_grant(8, c);
    checks++;
    if (vme_bg_out !== 4'b1011 || c > 4) begin
      errors++;
      $display("FAIL midreset_regrant: bg=%b after %0d clocks expected 1011 within 4", vme_bg_out, c);
    end
    vme_br = 4'hF;
    wait_bg(4'hF, 8, c);
    tick(2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
`ifndef VME_ARB_ROUND_ROBIN_EN
    test_preemption();
`else
    test_round_robin();
`endif
    test_random();
    test_timeout();
    test_slot1_disabled();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
